// File: rtl/bt_buf_reader.sv
// Read-side controller for the Bt buffer: issues buffer reads for a start/len request,
// absorbs the one-cycle blk_mem latency and streams words out through a 2-entry skid FIFO.
module bt_buf_reader #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] a_Bt,
  output logic              rd_en,
  input  logic [DATA_W-1:0] spo,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   a_q;
  logic [ADDR_W:0]     remaining;
  logic                inflight;
  logic                inflight_last;
  logic [DATA_W-1:0]   fifo_data [2];
  logic                fifo_last [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          fifo_cnt;
  logic [1:0]          occ;
  logic                pop;
  logic                push;
  logic                issue;
  logic                final_issue;
  logic [ADDR_W-1:0]   addr_next;

  assign occ         = fifo_cnt + {1'b0, inflight};
  assign m_valid     = (fifo_cnt != 2'd0);
  assign m_data      = fifo_data[rd_ptr];
  assign m_last      = fifo_last[rd_ptr];
  assign pop         = m_valid && m_ready;
  assign push        = inflight;
  // A slot freed by this cycle's pop may be reused by this cycle's issue.
  assign issue       = (state == READ) && (remaining != '0) &&
                       ((occ <= 2'd1) || ((occ == 2'd2) && pop));
  assign final_issue = issue && (remaining == (ADDR_W+1)'(1));
  assign addr_next   = (addr_q == ADDR_W'(DEPTH-1)) ? '0 : addr_q + ADDR_W'(1);
  assign rd_en       = issue;
  assign a_Bt        = issue ? addr_q : a_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      a_q           <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fifo_cnt      <= '0;
      done          <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= final_issue;

      if (issue) begin
        addr_q    <= addr_next;
        a_q       <= addr_q;
        remaining <= remaining - (ADDR_W+1)'(1);
      end

      if (push) begin
        fifo_data[wr_ptr] <= spo;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              addr_q    <= base_addr;
              remaining <= len;
              state     <= READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (final_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
